// File: rtl/db_ram_resp.sv
// db_ram_resp: on-chip stand-in for the DRAM PHY behind db_cont.
// Zero-fills the word store after every reset, then serves writes and
// fixed-latency, in-order reads. Requests seen during the fill are counted
// and discarded; out-of-range requests are counted, writes dropped, reads
// answered with zero so response ordering is kept.
module db_ram_resp #(
    parameter int unsigned RAM_ADDR   = 22,
    parameter int unsigned RAM_DWIDTH = 32,
    parameter int unsigned RAM_SIZE   = 1024,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [RAM_DWIDTH-1:0] wr_din,
    input  logic [RAM_ADDR-1:0]   addr,
    input  logic                  rd_en,
    output logic [RAM_DWIDTH-1:0] rd_dout,
    output logic                  rd_valid,
    output logic                  init_done,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           oor_cnt
);

    localparam int unsigned AW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic [15:0]           oor_cnt_q, oor_cnt_d;
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [RAM_DWIDTH-1:0] pipe_dat_q [RD_LATENCY];
    logic [RAM_DWIDTH-1:0] pipe_dat_d [RD_LATENCY];

    logic [RAM_DWIDTH-1:0] mem [RAM_SIZE];

    logic                  in_range;
    logic [AW-1:0]         req_idx;
    logic [RAM_DWIDTH-1:0] rd_word;
    logic                  mem_we;
    logic [AW-1:0]         mem_wa;
    logic [RAM_DWIDTH-1:0] mem_wd;

    // Address decode and read-before-write lookup of the current word.
    always_comb begin
        in_range = (64'(addr) < 64'(RAM_SIZE));
        req_idx  = addr[AW-1:0];
        rd_word  = mem[req_idx];
    end

    // Next-state logic: fill sequencing, request handling, counters, read pipe.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        drop_cnt_d    = drop_cnt_q;
        oor_cnt_d     = oor_cnt_q;
        mem_we        = 1'b0;
        mem_wa        = req_idx;
        mem_wd        = wr_din;
        pipe_vld_d    = '0;
        pipe_dat_d[0] = '0;

        case (state_q)
            S_INIT: begin
                mem_we = 1'b1;
                mem_wa = idx_q;
                mem_wd = '0;
                idx_d  = idx_q + AW'(1);
                if (idx_q == AW'(RAM_SIZE - 1)) begin
                    state_d = S_RUN;
                end
                if ((wr_en || rd_en) && (drop_cnt_q != '1)) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
            S_RUN: begin
                if (wr_en && in_range) begin
                    mem_we = 1'b1;
                end
                if (rd_en) begin
                    pipe_vld_d[0] = 1'b1;
                    if (in_range) begin
                        pipe_dat_d[0] = rd_word;
                    end
                end
                if ((wr_en || rd_en) && !in_range && (oor_cnt_q != '1)) begin
                    oor_cnt_d = oor_cnt_q + 16'd1;
                end
            end
            default: state_d = S_INIT;
        endcase

        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_dat_d[i] = pipe_dat_q[i-1];
        end
    end

    // State, counters and read pipeline; reset flushes in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            idx_q      <= '0;
            drop_cnt_q <= '0;
            oor_cnt_q  <= '0;
            pipe_vld_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_dat_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            drop_cnt_q <= drop_cnt_d;
            oor_cnt_q  <= oor_cnt_d;
            pipe_vld_q <= pipe_vld_d;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
        end
    end

    // Word store: single write port, no reset (contents cleared by the fill).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign rd_valid  = pipe_vld_q[RD_LATENCY-1];
    assign rd_dout   = pipe_dat_q[RD_LATENCY-1];
    assign init_done = (state_q == S_RUN);
    assign drop_cnt  = drop_cnt_q;
    assign oor_cnt   = oor_cnt_q;

endmodule

// File: tb/tb_db_ram_resp.sv
// Self-checking bench for db_ram_resp against a transaction-level model:
// a word array, an init-cycle countdown and a queue of expected responses
// tagged with the cycle on which each must appear.
module tb_db_ram_resp;

    localparam int unsigned RAM_ADDR   = 22;
    localparam int unsigned RAM_DWIDTH = 32;
    localparam int unsigned RAM_SIZE   = 1024;
    localparam int unsigned RD_LATENCY = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  wr_en = 1'b0;
    logic                  rd_en = 1'b0;
    logic [RAM_ADDR-1:0]   addr = '0;
    logic [RAM_DWIDTH-1:0] wr_din = '0;
    logic [RAM_DWIDTH-1:0] rd_dout;
    logic                  rd_valid;
    logic                  init_done;
    logic [15:0]           drop_cnt;
    logic [15:0]           oor_cnt;

    always #5 clk = ~clk;

    db_ram_resp #(
        .RAM_ADDR  (RAM_ADDR),
        .RAM_DWIDTH(RAM_DWIDTH),
        .RAM_SIZE  (RAM_SIZE),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_din   (wr_din),
        .addr     (addr),
        .rd_en    (rd_en),
        .rd_dout  (rd_dout),
        .rd_valid (rd_valid),
        .init_done(init_done),
        .drop_cnt (drop_cnt),
        .oor_cnt  (oor_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned           due;
        logic [RAM_DWIDTH-1:0] data;
    } resp_t;

    logic [RAM_DWIDTH-1:0] ref_mem [RAM_SIZE];
    int unsigned           init_left;
    int unsigned           ref_drop;
    int unsigned           ref_oor;
    int unsigned           cyc = 0;
    resp_t                 exp_q[$];

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        foreach (ref_mem[i]) ref_mem[i] = '0;
        init_left = RAM_SIZE;
        ref_drop  = 0;
        ref_oor   = 0;
        exp_q.delete();
    endtask

    // One clock: drive a request, advance the model, sample at the falling edge.
    task automatic tick(input logic w, input logic r, input logic [RAM_ADDR-1:0] a,
                        input logic [RAM_DWIDTH-1:0] d,
                        output logic ov, output logic [RAM_DWIDTH-1:0] od,
                        output logic ev, output logic [RAM_DWIDTH-1:0] ed);
        resp_t rsp;
        bit    ok;
        wr_en  = w;
        rd_en  = r;
        addr   = a;
        wr_din = d;
        @(posedge clk);
        cyc++;
        ok = (a < RAM_SIZE);
        if (init_left > 0) begin
            if (w || r) ref_drop = sat_inc(ref_drop);
            init_left--;
        end else begin
            if (r) begin
                rsp.due  = cyc + RD_LATENCY - 1;
                rsp.data = ok ? ref_mem[int'(a)] : '0;
                exp_q.push_back(rsp);
            end
            if ((w || r) && !ok) ref_oor = sat_inc(ref_oor);
            if (w && ok) ref_mem[int'(a)] = d;
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        ov = rd_valid;
        od = rd_dout;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev = 1'b1;
            ed = exp_q[0].data;
            void'(exp_q.pop_front());
        end else begin
            ev = 1'b0;
            ed = '0;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
        checks++; if (rd_dout !== '0) begin errors++; $display("FAIL reset_rd_dout: got %h expected 0", rd_dout); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %0b expected 0", init_done); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        checks++; if (oor_cnt !== 16'd0) begin errors++; $display("FAIL reset_oor_cnt: got %0d expected 0", oor_cnt); end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_init_drop();
        logic ov, ev;
        logic [RAM_DWIDTH-1:0] od, ed, first_data;
        int rise_edge = -1;
        int first_valid_edge = -1;
        for (int e = 1; e <= int'(RAM_SIZE + RD_LATENCY + 3); e++) begin
            tick(1'b0, 1'b1, 22'd5, '0, ov, od, ev, ed);
            checks++;
            if (ov !== ev || od !== ed) begin
                errors++;
                $display("FAIL init_resp edge %0d: got valid=%0b data=%h expected valid=%0b data=%h", e, ov, od, ev, ed);
            end
            checks++;
            if (init_done !== (init_left == 0)) begin
                errors++;
                $display("FAIL init_done edge %0d: got %0b expected %0b", e, init_done, init_left == 0);
            end
            if (init_done === 1'b1 && rise_edge < 0) rise_edge = e;
            if (ov === 1'b1 && first_valid_edge < 0) begin
                first_valid_edge = e;
                first_data = od;
            end
        end
        checks++;
        if (rise_edge != int'(RAM_SIZE)) begin errors++; $display("FAIL init_rise_edge: got %0d expected %0d", rise_edge, RAM_SIZE); end
        checks++;
        if (drop_cnt !== 16'(RAM_SIZE)) begin errors++; $display("FAIL init_drop_cnt: got %0d expected %0d", drop_cnt, RAM_SIZE); end
        checks++;
        if (first_valid_edge != int'(RAM_SIZE + RD_LATENCY) || first_data !== '0) begin
            errors++;
            $display("FAIL init_first_resp: got edge %0d data %h expected edge %0d data 0", first_valid_edge, first_data, RAM_SIZE + RD_LATENCY);
        end
        for (int i = 0; i < int'(RD_LATENCY); i++) tick(1'b0, 1'b0, '0, '0, ov, od, ev, ed);
    endtask

    task automatic test_write_read();
        logic ov, ev;
        logic [RAM_DWIDTH-1:0] od, ed;
        bit seen = 0;
        tick(1'b1, 1'b0, 22'd10, 32'hDEADBEEF, ov, od, ev, ed);
        for (int i = 0; i < int'(RD_LATENCY) + 2; i++) begin
            tick(1'b0, (i == 0), 22'd10, '0, ov, od, ev, ed);
            checks++;
            if (ov !== ev || od !== ed) begin
                errors++;
                $display("FAIL wr_rd_resp: got valid=%0b data=%h expected valid=%0b data=%h", ov, od, ev, ed);
            end
            if (ov === 1'b1 && od === 32'hDEADBEEF && i == int'(RD_LATENCY) - 1) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL wr_rd_data: got no 0xdeadbeef on cycle %0d after read, expected it", RD_LATENCY - 1); end
    endtask

    task automatic test_same_cycle();
        logic ov, ev;
        logic [RAM_DWIDTH-1:0] od, ed;
        logic [RAM_DWIDTH-1:0] got[$];
        tick(1'b1, 1'b0, 22'd20, 32'h22222222, ov, od, ev, ed);
        tick(1'b1, 1'b1, 22'd20, 32'h11111111, ov, od, ev, ed);
        if (ov === 1'b1) got.push_back(od);
        for (int i = 0; i < int'(RD_LATENCY) + 2; i++) begin
            tick(1'b0, (i == 0), 22'd20, '0, ov, od, ev, ed);
            checks++;
            if (ov !== ev || od !== ed) begin
                errors++;
                $display("FAIL rbw_resp: got valid=%0b data=%h expected valid=%0b data=%h", ov, od, ev, ed);
            end
            if (ov === 1'b1) got.push_back(od);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'h22222222 || got[1] !== 32'h11111111) begin
            errors++;
            $display("FAIL rbw_order: got %0d responses, expected 22222222 then 11111111", got.size());
        end
    endtask

    task automatic test_back_to_back();
        logic ov, ev;
        logic [RAM_DWIDTH-1:0] od, ed;
        logic [RAM_DWIDTH-1:0] got[$];
        int first = -1, last = -1;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 22'(i), 32'(i + 32'h100), ov, od, ev, ed);
        for (int i = 0; i < 8 + int'(RD_LATENCY) + 1; i++) begin
            tick(1'b0, (i < 8), 22'(i), '0, ov, od, ev, ed);
            checks++;
            if (ov !== ev || od !== ed) begin
                errors++;
                $display("FAIL b2b_resp %0d: got valid=%0b data=%h expected valid=%0b data=%h", i, ov, od, ev, ed);
            end
            if (ov === 1'b1) begin
                got.push_back(od);
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++;
        if (got.size() != 8 || last - first != 7) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses over %0d cycles, expected 8 over 8", got.size(), last - first + 1);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== 32'(i + 32'h100)) begin
                    errors++;
                    $display("FAIL b2b_data %0d: got %h expected %h", i, got[i], 32'(i + 32'h100));
                end
            end
        end
    endtask

    task automatic test_oor();
        logic ov, ev;
        logic [RAM_DWIDTH-1:0] od, ed;
        int nvalid = 0;
        logic [RAM_DWIDTH-1:0] vals[$];
        tick(1'b1, 1'b0, 22'd1024, 32'hAAAAAAAA, ov, od, ev, ed);
        tick(1'b0, 1'b1, 22'd1024, '0, ov, od, ev, ed);
        tick(1'b0, 1'b1, 22'd0, '0, ov, od, ev, ed);
        if (ov === 1'b1) vals.push_back(od);
        for (int i = 0; i < int'(RD_LATENCY) + 1; i++) begin
            tick(1'b0, 1'b0, '0, '0, ov, od, ev, ed);
            checks++;
            if (ov !== ev || od !== ed) begin
                errors++;
                $display("FAIL oor_resp: got valid=%0b data=%h expected valid=%0b data=%h", ov, od, ev, ed);
            end
            if (ov === 1'b1) vals.push_back(od);
        end
        nvalid = vals.size();
        checks++;
        if (nvalid != 2 || vals[0] !== '0 || vals[1] !== 32'h100) begin
            errors++;
            $display("FAIL oor_data: got %0d responses, expected 2 (00000000 then 00000100)", nvalid);
        end
        checks++;
        if (oor_cnt !== 16'd2) begin errors++; $display("FAIL oor_cnt: got %0d expected 2", oor_cnt); end
    endtask

    task automatic test_random();
        logic ov, ev;
        logic [RAM_DWIDTH-1:0] od, ed;
        logic [RAM_ADDR-1:0] a;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) a = 22'($urandom_range(1024, 4194303));
            else a = 22'($urandom_range(0, 63));
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, ov, od, ev, ed);
            checks++;
            if (ov !== ev || od !== ed) begin
                errors++;
                $display("FAIL rand_resp %0d: got valid=%0b data=%h expected valid=%0b data=%h", i, ov, od, ev, ed);
            end
            checks++;
            if (oor_cnt !== 16'(ref_oor)) begin
                errors++;
                $display("FAIL rand_oor_cnt %0d: got %0d expected %0d", i, oor_cnt, ref_oor);
            end
        end
        for (int i = 0; i < int'(RD_LATENCY); i++) tick(1'b0, 1'b0, '0, '0, ov, od, ev, ed);
        checks++;
        if (drop_cnt !== 16'(ref_drop)) begin errors++; $display("FAIL rand_drop_cnt: got %0d expected %0d", drop_cnt, ref_drop); end
    endtask

    task automatic test_reset_flush();
        logic ov, ev;
        logic [RAM_DWIDTH-1:0] od, ed;
        int rise_edge = -1;
        bit stray = 0;
        tick(1'b0, 1'b1, 22'd3, '0, ov, od, ev, ed);
        rd_en = 1'b1;
        addr  = 22'd4;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        rd_en = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2 * int'(RD_LATENCY) + 2; i++) begin
            if (rd_valid !== 1'b0) stray = 1;
            @(negedge clk);
        end
        checks++;
        if (stray) begin errors++; $display("FAIL flush_valid: got rd_valid=1 during reset, expected 0"); end
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL flush_init_done: got %0b expected 0", init_done); end
        rst = 1'b0;
        for (int e = 1; e <= int'(RAM_SIZE) + 2; e++) begin
            tick(1'b0, 1'b0, '0, '0, ov, od, ev, ed);
            checks++;
            if (ov !== ev || od !== ed) begin
                errors++;
                $display("FAIL flush_resp edge %0d: got valid=%0b data=%h expected valid=%0b data=%h", e, ov, od, ev, ed);
            end
            if (init_done === 1'b1 && rise_edge < 0) rise_edge = e;
        end
        checks++;
        if (rise_edge != int'(RAM_SIZE)) begin errors++; $display("FAIL flush_reinit: got rise at edge %0d expected %0d", rise_edge, RAM_SIZE); end
        tick(1'b0, 1'b1, 22'd10, '0, ov, od, ev, ed);
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            tick(1'b0, 1'b0, '0, '0, ov, od, ev, ed);
            checks++;
            if (ov !== ev || od !== ed) begin
                errors++;
                $display("FAIL rezero_resp: got valid=%0b data=%h expected valid=%0b data=%h", ov, od, ev, ed);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_init_drop();
        test_write_read();
        test_same_cycle();
        test_back_to_back();
        test_oor();
        test_random();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/db_ram_resp.md
# db_ram_resp

Memory-side responder for the `db_cont` DRAM interface: it accepts write and read requests on the `wr_en`/`wr_din`/`addr`/`rd_en` bus and returns in-order read data on `rd_dout`/`rd_valid` after a fixed latency. It holds the flow-table value store in on-chip RAM. It stands in for the external DRAM PHY until that PHY exists, so it must reproduce its request/response contract exactly. After every reset it zero-fills the store and only then begins serving requests.

## Interface
- `RAM_ADDR`, 22: width of `addr`.
- `RAM_DWIDTH`, 32: width of data words.
- `RAM_SIZE`, 1024: number of words stored; legal addresses are 0..RAM_SIZE-1.
- `RD_LATENCY`, 2: number of cycles from read request to `rd_valid`; legal values are 1..8.
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst`  in  1  Reset, asynchronous and active-high.
- `wr_en`  in  1  Write request, one cycle per request.
- `wr_din`  in  RAM_DWIDTH  Write data.
- `addr`  in  RAM_ADDR  Word address, shared by reads and writes.
- `rd_en`  in  1  Read request, one cycle per request.
- `rd_dout`  out  RAM_DWIDTH  Read data; 0 whenever `rd_valid` is low.
- `rd_valid`  out  1  Read response strobe.
- `init_done`  out  1  High once the zero-fill is complete.
- `drop_cnt`  out  16  Requests discarded during INIT; saturates at 0xFFFF.
- `oor_cnt`  out  16  Requests with `addr` >= RAM_SIZE; saturates at 0xFFFF.

## Operation
- Reset values: `rd_valid`=0, `rd_dout`=0, `init_done`=0, `drop_cnt`=0, `oor_cnt`=0. The FSM enters INIT, the init index is 0 and the read pipeline is empty.
- FSM states:
  - INIT: writes 0 to word[idx] each cycle and increments idx. When idx reaches RAM_SIZE-1 the FSM moves to RUN on the next edge.
  - RUN: terminal state; only `rst` leaves it.
- INIT lasts exactly RAM_SIZE cycles. `init_done` rises on the first RUN cycle.
- Requests during INIT: `wr_en` and/or `rd_en` are ignored, with no memory update and no response. `drop_cnt` increments by 1 per cycle in which either strobe is high.
- RUN write: if `addr` < RAM_SIZE, then word[addr] <= `wr_din`.
- RUN read: pushes a response into a RD_LATENCY-deep in-order shift pipeline. The response carries word[addr], or 0 if `addr` is out of range.
- Out of range (`addr` >= RAM_SIZE): the write is dropped. The read still returns exactly one `rd_valid` with data 0, so response ordering is preserved. `oor_cnt` increments by 1 per offending cycle, even if both strobes are high.
- `wr_en` and `rd_en` in the same cycle: both are performed. The read returns the pre-write contents (read-before-write).
- A read issued the cycle after a write to the same address returns the new data.
- Array indexing uses the low clog2(RAM_SIZE) bits of `addr`, and only after the range check.
- Counters saturate at 0xFFFF and never wrap.
- Reset mid-operation flushes all in-flight reads immediately: `rd_valid` goes 0 with no late responses. The FSM re-enters INIT and the memory is re-zeroed.

## Timing
- A request is sampled on edge N.
- `rd_valid`/`rd_dout` are registered outputs and are high for exactly one cycle, following edge N+RD_LATENCY-1. With RD_LATENCY=1 this means the cycle after the request.
- Full throughput: one read per cycle, back-to-back, with no stalls and no ready signal.
- Responses always return in request order.
- A write is visible to any read sampled on a later edge.
- Counters update on the edge that samples the request.
- `init_done` rises exactly RAM_SIZE edges after `rst` deasserts. With RAM_SIZE=1024 that is edge 1024.

## Test plan
- Reset, then hold `rd_en`=1 at `addr`=5 from the first post-reset edge onward. Required: `init_done` rises after 1024 edges, `drop_cnt`=1024, and the first `rd_valid` carries 0x00000000 two cycles after the first RUN-state read.
- Write 0xDEADBEEF to addr 10, then read addr 10 on the next cycle. Required: `rd_dout`=0xDEADBEEF with `rd_valid` 2 cycles after the read.
- Same cycle: `wr_en`=1, `rd_en`=1, addr 20, `wr_din`=0x11111111, with word[20] holding 0x22222222. Required: the read returns 0x22222222, and a following read returns 0x11111111.
- 8 back-to-back reads of addrs 0..7 after writing data equal to addr+0x100. Required: 8 consecutive `rd_valid` cycles with data 0x100..0x107 in order.
- Write 0xAAAAAAAA to addr 1024, then read addr 1024. Required: the read returns 0 with `rd_valid`=1, `oor_cnt`=2, and word[0] is unchanged.
- Assert `rst` while 2 reads are in flight. Required: no `rd_valid` ever appears for them, `init_done`=0, and INIT restarts.
